// File: rtl/sqrt_arb_pkg.sv
// Shared definitions for the square-root engine arbiter: FSM encoding and
// a constant-width helper used to size the pointer and timeout counter.
package sqrt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Never returns less than 1 so a degenerate range still gets a real vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/sqrt_arbiter_if.sv
// Start/valid handshake between the arbiter (master) and the single sqrt engine (slave).
// eng_start pulses for one cycle with eng_operand held stable; the engine later
// raises eng_valid for one cycle with eng_result, which is only honoured while the arbiter waits.
interface sqrt_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int RES_W = WIDTH / 2
);
    logic             eng_start;
    logic [WIDTH-1:0] eng_operand;
    logic             eng_valid;
    logic [RES_W-1:0] eng_result;

    modport master (
        output eng_start,
        output eng_operand,
        input  eng_valid,
        input  eng_result
    );

    modport slave (
        input  eng_start,
        input  eng_operand,
        output eng_valid,
        output eng_result
    );
endinterface

// File: rtl/sqrt_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping modulo N_REQ (works for non-power-of-two N_REQ).
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             any,
    output logic [PTR_W-1:0] gidx
);
    always_comb begin : pick
        logic             found;
        logic [PTR_W-1:0] idx;
        any   = |req;
        gidx  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end
endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one integer square-root engine among N_REQ clients.
// Every client-facing and engine-facing output is registered.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int RES_W   = WIDTH / 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] operand,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       done,
    output logic [RES_W-1:0]       result,
    output logic                   err,
    output logic                   busy,
    output state_t                 dbg_state,
    sqrt_arbiter_if.master         eng
);
    localparam int PTR_W = clog2(N_REQ);
    localparam int TMR_W = clog2(TIMEOUT + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic [TMR_W-1:0] timer;
    logic             timeout_hit;

    rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .gidx   (pick_idx)
    );

    // timer only reaches TMR_LAST before leaving WAIT, so it never overflows.
    assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_LAST);
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_any) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (eng.eng_valid || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs and datapath; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            ack             <= '0;
            done            <= '0;
            result          <= '0;
            err             <= 1'b0;
            busy            <= 1'b0;
            eng.eng_start   <= 1'b0;
            eng.eng_operand <= '0;
            rr_ptr          <= '0;
            gidx            <= '0;
            timer           <= '0;
        end else begin
            ack           <= '0;
            done          <= '0;
            eng.eng_start <= 1'b0;
            busy          <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gidx            <= pick_idx;
                        eng.eng_operand <= operand[pick_idx*WIDTH +: WIDTH];
                        ack             <= N_REQ'(1) << pick_idx;
                        eng.eng_start   <= 1'b1;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    // A valid arriving on the timeout cycle still wins.
                    if (eng.eng_valid) begin
                        result <= eng.eng_result;
                        err    <= 1'b0;
                        done   <= N_REQ'(1) << gidx;
                    end else if (timeout_hit) begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= N_REQ'(1) << gidx;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    err    <= 1'b0;
                    rr_ptr <= (gidx == PTR_LAST) ? '0 : gidx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a small engine model (auto latency or manual drive).
module tb_sqrt_arbiter;
    import sqrt_arb_pkg::*;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 16;
    localparam int RES_W   = 8;
    localparam int TIMEOUT = 8;

    logic                   clk = 1'b0;
    logic                   clr;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] operand;
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       done;
    logic [RES_W-1:0]       result;
    logic                   err;
    logic                   busy;
    state_t                 dbg_state;

    sqrt_arbiter_if #(.WIDTH(WIDTH), .RES_W(RES_W)) eng ();

    sqrt_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .operand   (operand),
        .ack       (ack),
        .done      (done),
        .result    (result),
        .err       (err),
        .busy      (busy),
        .dbg_state (dbg_state),
        .eng       (eng)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit eng_auto = 1'b0;
    int eng_lat  = 3;
    int eng_pend = 0;

    function automatic logic [RES_W-1:0] isqrt(input logic [WIDTH-1:0] v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r = r + 1;
        return RES_W'(r);
    endfunction

    // Engine model: in auto mode answers isqrt(eng_operand) eng_lat cycles after eng_start.
    initial begin
        eng.eng_valid  = 1'b0;
        eng.eng_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (eng_auto) begin
                eng.eng_valid = 1'b0;
                if (eng_pend > 0) begin
                    eng_pend = eng_pend - 1;
                    if (eng_pend == 0) begin
                        eng.eng_valid  = 1'b1;
                        eng.eng_result = isqrt(eng.eng_operand);
                    end
                end
                if (eng.eng_start) eng_pend = eng_lat;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == '0 && n < max);
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done == '0 && n < max);
    endtask

    task automatic set_op(input int idx, input logic [WIDTH-1:0] v);
        operand[idx*WIDTH +: WIDTH] = v;
    endtask

    task automatic run_txn(input string tag, input int idx, input logic [WIDTH-1:0] exp_op,
                           input logic [RES_W-1:0] exp_res, output int an, output int dn);
        wait_ack(30, an);
        check({tag, " ack"}, 32'(ack), 32'(1) << idx);
        check({tag, " eng_start"}, 32'(eng.eng_start), 32'd1);
        check({tag, " eng_operand"}, 32'(eng.eng_operand), 32'(exp_op));
        req[idx] = 1'b0;
        wait_done(30, dn);
        check({tag, " done"}, 32'(done), 32'(1) << idx);
        check({tag, " result"}, 32'(result), 32'(exp_res));
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int an;
        int dn;
        logic [WIDTH-1:0] ops [4];
        logic [RES_W-1:0] exps [4];
        clr     = 1'b1;
        req     = '0;
        operand = '0;
        tick();
        tick();
        check("rst ack", 32'(ack), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst eng_start", 32'(eng.eng_start), 32'd0);
        check("rst eng_operand", 32'(eng.eng_operand), 32'd0);
        check("rst state", 32'(dbg_state), 32'(IDLE));
        clr = 1'b0;

        // Single request, engine latency 5.
        eng_auto = 1'b1;
        eng_lat  = 5;
        set_op(2, 16'd144);
        req = 4'b0100;
        run_txn("single", 2, 16'd144, 8'd12, an, dn);
        check("single ack latency", 32'(an), 32'd1);
        check("single done latency", 32'(dn), 32'd6);
        tick();
        check("single done clears", 32'(done), 32'd0);
        check("single result held", 32'(result), 32'd12);
        check("single busy drops", 32'(busy), 32'd0);

        // All four requesters right after reset, latency 3.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ops  = '{16'd0, 16'd1, 16'd65535, 16'd99};
        exps = '{8'd0, 8'd1, 8'd255, 8'd9};
        for (int i = 0; i < 4; i++) set_op(i, ops[i]);
        eng_lat = 3;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("all%0d", i), i, ops[i], exps[i], an, dn);
            check($sformatf("all%0d done latency", i), 32'(dn), 32'd4);
            if (i > 0) check($sformatf("all%0d ack gap", i), 32'(an), 32'd2);
        end

        // Pointer fairness: after serving 1, requesters 0 and 2 together -> 2 first.
        set_op(1, 16'd49);
        req = 4'b0010;
        run_txn("fair1", 1, 16'd49, 8'd7, an, dn);
        set_op(0, 16'd25);
        set_op(2, 16'd36);
        req = 4'b0101;
        run_txn("fair2", 2, 16'd36, 8'd6, an, dn);
        run_txn("fair0", 0, 16'd25, 8'd5, an, dn);

        // Timeout: engine never answers.
        eng_auto = 1'b0;
        eng.eng_valid = 1'b0;
        set_op(1, 16'd50);
        req = 4'b0010;
        wait_ack(30, an);
        check("tmo ack", 32'(ack), 32'b0010);
        req = 4'b0000;
        wait_done(30, dn);
        check("tmo latency", 32'(dn), 32'd9);
        check("tmo done", 32'(done), 32'b0010);
        check("tmo err", 32'(err), 32'd1);
        check("tmo result", 32'(result), 32'd0);
        tick();
        check("tmo err clears", 32'(err), 32'd0);
        check("tmo done clears", 32'(done), 32'd0);
        eng_auto = 1'b1;
        eng_lat  = 2;
        set_op(3, 16'd81);
        req = 4'b1000;
        run_txn("after tmo", 3, 16'd81, 8'd9, an, dn);

        // clr while waiting, late engine valid must be dropped.
        eng_auto = 1'b0;
        eng.eng_valid = 1'b0;
        set_op(0, 16'd64);
        req = 4'b0001;
        wait_ack(30, an);
        check("abort ack", 32'(ack), 32'b0001);
        req = 4'b0000;
        tick();
        tick();
        check("abort in wait", 32'(dbg_state), 32'(WAIT));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort ack", 32'(ack), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort err", 32'(err), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort eng_start", 32'(eng.eng_start), 32'd0);
        check("abort eng_operand", 32'(eng.eng_operand), 32'd0);
        check("abort state", 32'(dbg_state), 32'(IDLE));
        tick();
        eng.eng_valid  = 1'b1;
        eng.eng_result = 8'hAA;
        tick();
        eng.eng_valid = 1'b0;
        check("late valid done", 32'(done), 32'd0);
        check("late valid result", 32'(result), 32'd0);
        tick();
        check("late valid done2", 32'(done), 32'd0);
        check("late valid state", 32'(dbg_state), 32'(IDLE));
        eng_auto = 1'b1;
        eng_lat  = 3;
        set_op(3, 16'd16);
        req = 4'b1000;
        run_txn("post clr", 3, 16'd16, 8'd4, an, dn);

        // Stray valid in IDLE, then valid on the exact timeout cycle.
        eng_auto = 1'b0;
        tick();
        eng.eng_valid  = 1'b1;
        eng.eng_result = 8'h55;
        tick();
        eng.eng_valid = 1'b0;
        tick();
        check("stray done", 32'(done), 32'd0);
        check("stray result", 32'(result), 32'd4);
        check("stray state", 32'(dbg_state), 32'(IDLE));
        set_op(2, 16'd200);
        req = 4'b0100;
        wait_ack(30, an);
        check("coll ack", 32'(ack), 32'b0100);
        req = 4'b0000;
        for (int k = 0; k < 8; k++) tick();
        check("coll no early done", 32'(done), 32'd0);
        eng.eng_valid  = 1'b1;
        eng.eng_result = 8'h3C;
        tick();
        eng.eng_valid = 1'b0;
        check("coll done", 32'(done), 32'b0100);
        check("coll result", 32'(result), 32'h3C);
        check("coll err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
